// File: rtl/fifo_write_arbiter_if.sv
// Write-side bus between the requesters, the arbiter and the FIFO.
// slave: arbiter view; master: requester/FIFO (environment) view.
`timescale 1ns/1ps
interface fifo_write_arbiter_if #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8
);
   logic [NUM_REQ-1:0]            req_valid;
   logic [NUM_REQ-1:0]            req_ready;
   logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]            req_last;
   logic                          fifo_valid;
   logic                          fifo_ready;
   logic                          fifo_almost_full;
   logic [DATA_WIDTH-1:0]         fifo_data;

   modport slave (
      input  req_valid, req_data, req_last,
      input  fifo_ready, fifo_almost_full,
      output req_ready, fifo_valid, fifo_data
   );

   modport master (
      output req_valid, req_data, req_last,
      output fifo_ready, fifo_almost_full,
      input  req_ready, fifo_valid, fifo_data
   );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin packet arbiter for the async_fifo write port.
// Ports: clock, reset_n (async low); bus (slave modport:
// req_valid/req_ready/req_data/req_last in, fifo_valid/
// fifo_data out, fifo_ready/fifo_almost_full in); grant
// (one-hot), busy, timeout_error (one-cycle pulse).
// Optional macro FIFO_ARBITER_TIMEOUT_EN: abort a packet
// after TIMEOUT idle cycles of the granted requester.
`timescale 1ns/1ps
module fifo_write_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int TIMEOUT    = 16
) (
   input  logic               clock,
   input  logic               reset_n,
   fifo_write_arbiter_if.slave bus,
   output logic [NUM_REQ-1:0] grant,
   output logic               busy,
   output logic               timeout_error
);
   localparam int IDX_W = $clog2(NUM_REQ);

   typedef enum logic {
      IDLE   = 1'b0,
      PACKET = 1'b1
   } state_t;

   state_t             state;
   state_t             state_nx;
   logic [NUM_REQ-1:0] grant_nx;
   logic [IDX_W-1:0]   cur_idx;
   logic [IDX_W-1:0]   cur_idx_nx;
   logic [IDX_W-1:0]   last_idx;
   logic [IDX_W-1:0]   last_idx_nx;
   logic [IDX_W-1:0]   sel_idx;
   logic [IDX_W-1:0]   cand;
   logic               sel_found;
   logic               g_valid;
   logic               g_last;
   logic               xfer;
   logic               abort;

   generate
      if (NUM_REQ < 2 || NUM_REQ > 8 ||
          TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad
         $error("fifo_write_arbiter: bad parameter");
      end
   endgenerate

   assign g_valid = bus.req_valid[cur_idx];
   assign g_last  = bus.req_last[cur_idx];
   assign xfer    = (state == PACKET) & g_valid
                  & bus.fifo_ready;

   // Scan starts one past the last winner, wrapping.
   always_comb begin
      sel_found = 1'b0;
      sel_idx   = '0;
      cand      = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         cand = IDX_W'((int'(last_idx) + k) % NUM_REQ);
         if (!sel_found && bus.req_valid[cand]) begin
            sel_found = 1'b1;
            sel_idx   = cand;
         end
      end
   end

`ifdef FIFO_ARBITER_TIMEOUT_EN
   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   logic [7:0] idle_cnt;
   logic [7:0] idle_cnt_nx;

   // Abort on the edge where the count would reach TIMEOUT.
   assign abort = (state == PACKET) & ~g_valid
                & (idle_cnt == TO_LAST);

   always_comb begin
      idle_cnt_nx = '0;
      if (state == PACKET && !g_valid)
         idle_cnt_nx = idle_cnt + 8'd1;
   end
`else
   assign abort         = 1'b0;
   assign timeout_error = 1'b0;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state    <= IDLE;
         grant    <= '0;
         cur_idx  <= '0;
         last_idx <= IDX_W'(NUM_REQ - 1);
`ifdef FIFO_ARBITER_TIMEOUT_EN
         idle_cnt      <= '0;
         timeout_error <= 1'b0;
`endif
      end else begin
         state    <= state_nx;
         grant    <= grant_nx;
         cur_idx  <= cur_idx_nx;
         last_idx <= last_idx_nx;
`ifdef FIFO_ARBITER_TIMEOUT_EN
         idle_cnt      <= idle_cnt_nx;
         timeout_error <= abort;
`endif
      end
   end

   always_comb begin
      state_nx    = state;
      grant_nx    = grant;
      cur_idx_nx  = cur_idx;
      last_idx_nx = last_idx;
      unique case (state)
         IDLE: begin
            if (sel_found && !bus.fifo_almost_full) begin
               state_nx          = PACKET;
               grant_nx          = '0;
               grant_nx[sel_idx] = 1'b1;
               cur_idx_nx        = sel_idx;
            end
         end
         PACKET: begin
            if ((xfer && g_last) || abort) begin
               state_nx    = IDLE;
               grant_nx    = '0;
               last_idx_nx = cur_idx;
            end
         end
         default: ;
      endcase
   end

   // Pass-through: no data register on this path.
   always_comb begin
      busy           = (state == PACKET);
      bus.fifo_valid = 1'b0;
      bus.fifo_data  = '0;
      bus.req_ready  = '0;
      if (state == PACKET) begin
         bus.fifo_valid         = g_valid;
         bus.fifo_data          =
            bus.req_data[cur_idx*DATA_WIDTH +: DATA_WIDTH];
         bus.req_ready[cur_idx] = bus.fifo_ready;
      end
   end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter.
// Directed scenarios plus a randomized run against a model.
`timescale 1ns/1ps
module tb_fifo_write_arbiter;
   localparam int NR = 4;
   localparam int DW = 8;
   localparam int TO = 16;

   logic          clock = 1'b0;
   logic          reset_n;
   logic [NR-1:0] grant;
   logic          busy;
   logic          timeout_error;
   int            errors = 0;
   int            checks = 0;
   int            widx [NR];

   fifo_write_arbiter_if #(
      .NUM_REQ(NR), .DATA_WIDTH(DW)
   ) bus ();

   fifo_write_arbiter #(
      .NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)
   ) dut (
      .clock(clock),
      .reset_n(reset_n),
      .bus(bus),
      .grant(grant),
      .busy(busy),
      .timeout_error(timeout_error)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic clear_inputs();
      bus.req_valid        = '0;
      bus.req_last         = '0;
      bus.req_data         = '0;
      bus.fifo_ready       = 1'b1;
      bus.fifo_almost_full = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset_n      = 1'b0;
      bus.req_valid = 4'b1111;
      bus.req_data  = 32'h44332211;
      repeat (3) tick();
      checks++;
      if (grant !== 4'b0000) begin
         errors++;
         $display("FAIL reset_grant got=%b want=0000", grant);
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy got=%b want=0", busy);
      end
      checks++;
      if (bus.fifo_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_fvalid got=%b want=0",
                  bus.fifo_valid);
      end
      checks++;
      if (bus.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL reset_ready got=%b want=0000",
                  bus.req_ready);
      end
      checks++;
      if (timeout_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_tmo got=%b want=0",
                  timeout_error);
      end
      reset_n = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL first_grant got=%b want=0001", grant);
      end
      checks++;
      if (busy !== 1'b1 || bus.fifo_data !== 8'h11) begin
         errors++;
         $display("FAIL first_pass got=%b/%h want=1/11",
                  busy, bus.fifo_data);
      end
      bus.req_last = 4'b1111;
      tick();
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_word got=%b/%b want=0000/0",
                  grant, busy);
      end
      clear_inputs();
   endtask

   task automatic drive_rot();
      for (int i = 0; i < NR; i++) begin
         bus.req_valid[i] = (widx[i] < 2);
         bus.req_last[i]  = (widx[i] == 1);
         bus.req_data[i*DW +: DW] =
            8'(8'hA0 + 16*i + widx[i]);
      end
   endtask

   task automatic test_rotation();
      logic [7:0] got [$];
      int         cyc [$];
      logic [7:0] exp;
      do_reset();
      for (int i = 0; i < NR; i++) widx[i] = 0;
      drive_rot();
      for (int c = 0; c < 30; c++) begin
         @(negedge clock);
         if (bus.fifo_valid && bus.fifo_ready) begin
            got.push_back(bus.fifo_data);
            cyc.push_back(c);
         end
         for (int i = 0; i < NR; i++)
            if (bus.req_valid[i] && bus.req_ready[i])
               widx[i]++;
         tick();
         drive_rot();
      end
      checks++;
      if (got.size() != 8) begin
         errors++;
         $display("FAIL rot_count got=%0d want=8", got.size());
      end
      for (int k = 0; k < 8 && k < got.size(); k++) begin
         exp = 8'(8'hA0 + 16*(k/2) + (k%2));
         checks++;
         if (got[k] !== exp) begin
            errors++;
            $display("FAIL rot_word%0d got=%h want=%h",
                     k, got[k], exp);
         end
      end
      for (int p = 1; p < 4 && 2*p < cyc.size(); p++) begin
         checks++;
         if (cyc[2*p] - cyc[2*p-1] != 2) begin
            errors++;
            $display("FAIL rot_gap%0d got=%0d want=2",
                     p, cyc[2*p] - cyc[2*p-1]);
         end
      end
      clear_inputs();
   endtask

   task automatic test_backpressure();
      logic [7:0] words [3];
      logic [7:0] got [$];
      int         w = 0;
      int         low_left = 0;
      int         lowcnt = 0;
      words[0] = 8'h11;
      words[1] = 8'h22;
      words[2] = 8'h33;
      do_reset();
      for (int c = 0; c < 30; c++) begin
         bus.req_valid[2] = (w < 3);
         bus.req_last[2]  = (w == 2);
         bus.req_data[2*DW +: DW] = words[w < 3 ? w : 2];
         @(negedge clock);
         if (busy) begin
            checks++;
            if (grant !== 4'b0100) begin
               errors++;
               $display("FAIL bp_grant got=%b want=0100", grant);
            end
            checks++;
            if (bus.req_ready !==
                (bus.fifo_ready ? 4'b0100 : 4'b0000)) begin
               errors++;
               $display("FAIL bp_ready got=%b fifo_ready=%b",
                        bus.req_ready, bus.fifo_ready);
            end
            if (!bus.req_ready[2]) lowcnt++;
         end
         if (bus.fifo_valid && bus.fifo_ready)
            got.push_back(bus.fifo_data);
         if (bus.req_valid[2] && bus.req_ready[2]) begin
            if (w == 0) low_left = 5;
            w++;
         end
         tick();
         if (low_left > 0) begin
            bus.fifo_ready = 1'b0;
            low_left--;
         end else begin
            bus.fifo_ready = 1'b1;
         end
      end
      checks++;
      if (got.size() != 3) begin
         errors++;
         $display("FAIL bp_count got=%0d want=3", got.size());
      end
      for (int k = 0; k < 3 && k < got.size(); k++) begin
         checks++;
         if (got[k] !== words[k]) begin
            errors++;
            $display("FAIL bp_word%0d got=%h want=%h",
                     k, got[k], words[k]);
         end
      end
      checks++;
      if (lowcnt != 5) begin
         errors++;
         $display("FAIL bp_stall got=%0d want=5", lowcnt);
      end
      clear_inputs();
   endtask

   task automatic test_almost_full();
      do_reset();
      bus.fifo_almost_full = 1'b1;
      bus.req_valid        = 4'b0010;
      bus.req_last         = 4'b0010;
      bus.req_data[1*DW +: DW] = 8'h5A;
      for (int k = 0; k < 10; k++) begin
         tick();
         checks++;
         if (grant !== 4'b0000) begin
            errors++;
            $display("FAIL af_hold%0d got=%b want=0000",
                     k, grant);
         end
      end
      bus.fifo_almost_full = 1'b0;
      tick();
      checks++;
      if (grant !== 4'b0010 || bus.fifo_data !== 8'h5A) begin
         errors++;
         $display("FAIL af_grant got=%b/%h want=0010/5a",
                  grant, bus.fifo_data);
      end
      tick();
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL af_done got=%b want=0", busy);
      end
      clear_inputs();
   endtask

   task automatic test_timeout();
      do_reset();
      bus.req_valid = 4'b1000;
      bus.req_data[3*DW +: DW] = 8'h77;
      tick();
      checks++;
      if (grant !== 4'b1000) begin
         errors++;
         $display("FAIL to_grant got=%b want=1000", grant);
      end
      tick();
      bus.req_valid = 4'b0001;
      bus.req_last  = 4'b0001;
`ifdef FIFO_ARBITER_TIMEOUT_EN
      for (int k = 1; k <= TO; k++) begin
         tick();
         checks++;
         if (timeout_error !== (k == TO)) begin
            errors++;
            $display("FAIL to_pulse%0d got=%b want=%b",
                     k, timeout_error, (k == TO));
         end
         checks++;
         if (grant !== ((k < TO) ? 4'b1000 : 4'b0000)) begin
            errors++;
            $display("FAIL to_hold%0d got=%b", k, grant);
         end
      end
      tick();
      checks++;
      if (timeout_error !== 1'b0 || grant !== 4'b0001) begin
         errors++;
         $display("FAIL to_next got=%b/%b want=0/0001",
                  timeout_error, grant);
      end
`else
      for (int k = 1; k <= 20; k++) begin
         tick();
         checks++;
         if (timeout_error !== 1'b0 || grant !== 4'b1000) begin
            errors++;
            $display("FAIL stall_hold%0d got=%b/%b want=0/1000",
                     k, timeout_error, grant);
         end
      end
`endif
      clear_inputs();
   endtask

   task automatic test_mid_reset();
      do_reset();
      bus.req_valid = 4'b0010;
      bus.req_data[1*DW +: DW] = 8'hC0;
      tick();
      checks++;
      if (grant !== 4'b0010) begin
         errors++;
         $display("FAIL mr_grant got=%b want=0010", grant);
      end
      tick();
      bus.req_data[1*DW +: DW] = 8'hC1;
      tick();
      bus.req_data[1*DW +: DW] = 8'hC2;
      #1;
      checks++;
      if (bus.fifo_valid !== 1'b1 ||
          bus.fifo_data !== 8'hC2) begin
         errors++;
         $display("FAIL mr_pass got=%b/%h want=1/c2",
                  bus.fifo_valid, bus.fifo_data);
      end
      reset_n       = 1'b0;
      bus.req_valid = 4'b0011;
      #1;
      checks++;
      if (grant !== 4'b0000 || busy !== 1'b0) begin
         errors++;
         $display("FAIL mr_async got=%b/%b want=0000/0",
                  grant, busy);
      end
      checks++;
      if (bus.fifo_valid !== 1'b0 ||
          bus.req_ready !== 4'b0000) begin
         errors++;
         $display("FAIL mr_outs got=%b/%b want=0/0000",
                  bus.fifo_valid, bus.req_ready);
      end
      tick();
      reset_n = 1'b1;
      tick();
      checks++;
      if (grant !== 4'b0001) begin
         errors++;
         $display("FAIL mr_regrant got=%b want=0001", grant);
      end
      clear_inputs();
   endtask

   task automatic test_random();
      int         plen [NR];
      int         pos  [NR];
      logic [7:0] word [NR];
      logic [7:0] expq [$];
      logic [7:0] got  [$];
      int         owner = -1;
      int         owner_nx;
      int         mlast = NR - 1;
      int         j;
      logic [3:0] eg;
      logic       ev;
      do_reset();
      for (int i = 0; i < NR; i++) begin
         plen[i] = $urandom_range(1, 4);
         pos[i]  = 0;
         word[i] = 8'($urandom);
      end
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < NR; i++) begin
            bus.req_valid[i] = ($urandom_range(0, 99) < 85);
            bus.req_last[i]  = (pos[i] == plen[i] - 1);
            bus.req_data[i*DW +: DW] = word[i];
         end
         bus.fifo_ready       = ($urandom_range(0, 99) < 75);
         bus.fifo_almost_full = ($urandom_range(0, 99) < 20);
         @(negedge clock);
         eg = (owner < 0) ? 4'b0000 : 4'(4'b0001 << owner);
         ev = (owner >= 0) && bus.req_valid[owner];
         checks++;
         if (grant !== eg || busy !== (owner >= 0)) begin
            errors++;
            $display("FAIL rnd_grant c=%0d got=%b/%b want=%b",
                     c, grant, busy, eg);
         end
         checks++;
         if (bus.fifo_valid !== ev) begin
            errors++;
            $display("FAIL rnd_fvalid c=%0d got=%b want=%b",
                     c, bus.fifo_valid, ev);
         end
         if (ev) begin
            checks++;
            if (bus.fifo_data !== word[owner]) begin
               errors++;
               $display("FAIL rnd_data c=%0d got=%h want=%h",
                        c, bus.fifo_data, word[owner]);
            end
         end
         checks++;
         if (bus.req_ready !==
             (bus.fifo_ready ? eg : 4'b0000)) begin
            errors++;
            $display("FAIL rnd_ready c=%0d got=%b want=%b",
                     c, bus.req_ready,
                     bus.fifo_ready ? eg : 4'b0000);
         end
         if (bus.fifo_valid && bus.fifo_ready)
            got.push_back(bus.fifo_data);
         owner_nx = owner;
         if (owner < 0) begin
            if (!bus.fifo_almost_full) begin
               for (int k = 1; k <= NR; k++) begin
                  j = (mlast + k) % NR;
                  if (owner_nx < 0 && bus.req_valid[j])
                     owner_nx = j;
               end
            end
         end else if (ev && bus.fifo_ready) begin
            expq.push_back(word[owner]);
            word[owner] = 8'($urandom);
            pos[owner]++;
            if (pos[owner] == plen[owner]) begin
               pos[owner]  = 0;
               plen[owner] = $urandom_range(1, 4);
               mlast       = owner;
               owner_nx    = -1;
            end
         end
         tick();
         owner = owner_nx;
      end
      checks++;
      if (got.size() != expq.size()) begin
         errors++;
         $display("FAIL rnd_count got=%0d want=%0d",
                  got.size(), expq.size());
      end
      for (int k = 0; k < expq.size() && k < got.size();
           k++) begin
         checks++;
         if (got[k] !== expq[k]) begin
            errors++;
            $display("FAIL rnd_stream%0d got=%h want=%h",
                     k, got[k], expq[k]);
         end
      end
      clear_inputs();
   endtask

   initial begin
      reset_n = 1'b0;
      clear_inputs();
      test_reset();
      test_rotation();
      test_backpressure();
      test_almost_full();
      test_timeout();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks",
               errors, checks);
      $finish;
   end
endmodule
